// File: rtl/seg_mmio_pkg.sv
// seg_mmio_pkg: register map, CTRL fields and display constants for seg_mmio
package seg_mmio_pkg;
  localparam logic [1:0] OFF_DATA = 2'd0;
  localparam logic [1:0] OFF_CTRL = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;
  localparam logic [1:0] OFF_RSVD = 2'd3;
  localparam int CTRL_EN = 0;
  localparam int CTRL_DP_LSB = 4;
  localparam int NUM_DIGITS = 4;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
endpackage

// File: rtl/hex7seg_decode.sv
// hex7seg_decode: 4-bit hex to active-low {g,f,e,d,c,b,a} segments
module hex7seg_decode (
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  always_comb begin
    case (hex)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
  end
endmodule

// File: rtl/seg_mmio.sv
// seg_mmio: memory-mapped 4-digit multiplexed 7-segment display controller
// Optional SEG_MMIO_BLANK_LEADING_EN blanks leading zero digits.
module seg_mmio
  import seg_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_2000,
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enabler,
  input  logic        write_enabler,
  input  logic [31:0] addr,
  input  logic [3:0]  select,
  input  logic [31:0] data_input,
  output logic [31:0] data_output,
  output logic        hit,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp
);
  localparam logic [15:0] CNT_LAST = 16'(SCAN_DIV - 1);
  logic [31:0] data_r;
  logic [3:0] dp_mask;
  logic en_r;
  logic [15:0] cnt;
  logic [$clog2(NUM_DIGITS)-1:0] idx;
  logic [1:0] off;
  logic wr;
  logic [31:0] ctrl_val;
  logic [31:0] rdata;
  logic [6:0] dec;
  logic lead_zero;
  logic off_n;
  logic unused;
  assign unused = &{1'b0, addr[1:0]};
  assign off = addr[3:2];
  assign hit = enabler && addr[31:4] == BASE_ADDR[31:4];
  assign wr = hit && write_enabler;
  assign ctrl_val = {24'h0, dp_mask, 3'b000, en_r};
  always_comb begin
    rdata = off == OFF_DATA ? data_r :
            off == OFF_CTRL ? ctrl_val :
            off == OFF_STATUS ? {30'h0, idx} :
            off == OFF_RSVD ? 32'h0 : 32'h0;
  end
  assign data_output = hit && !write_enabler ? rdata : 32'h0;
  hex7seg_decode u_dec (.hex(data_r[{idx, 2'b00} +: 4]), .seg(dec));
`ifdef SEG_MMIO_BLANK_LEADING_EN
  assign lead_zero = idx != 2'd0 && (data_r[15:0] >> {idx, 2'b00}) == 16'h0;
`else
  assign lead_zero = 1'b0;
`endif
  assign off_n = !en_r || lead_zero;
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r <= 32'h0;
      en_r <= 1'b1;
      dp_mask <= 4'h0;
      cnt <= 16'h0;
      idx <= '0;
      an <= 4'b1110;
      seg <= 7'b1000000;
      dp <= 1'b1;
    end else begin
      for (int b = 0; b < 4; b++)
        if (wr && off == OFF_DATA && select[b]) data_r[8*b +: 8] <= data_input[8*b +: 8];
      if (wr && off == OFF_CTRL && select[0]) begin
        en_r <= data_input[CTRL_EN];
        dp_mask <= data_input[CTRL_DP_LSB +: 4];
      end
      cnt <= cnt == CNT_LAST ? 16'h0 : cnt + 16'h1;
      if (cnt == CNT_LAST) idx <= idx + 1'b1;
      an <= off_n ? 4'b1111 : ~(4'b0001 << idx);
      seg <= off_n ? SEG_BLANK : dec;
      dp <= off_n || !dp_mask[idx];
    end
  end
endmodule

// File: tb/tb_seg_mmio.sv
// tb_seg_mmio: directed scoreboard bench for seg_mmio with SCAN_DIV=4
module tb_seg_mmio;
  localparam logic [31:0] B = 32'h0000_2000;
  typedef struct {
    string tag;
    logic [31:0] val;
  } exp_t;
  logic clk = 0, rst = 1, enabler = 0, write_enabler = 0;
  logic [31:0] addr = 0, data_input = 0;
  logic [3:0] select = 0;
  logic [31:0] data_output;
  logic hit, dp;
  logic [6:0] seg;
  logic [3:0] an;
  int vectors = 0, errors = 0, cyc = 0;
  logic [31:0] data_m = 0, ctrl_m = 32'h1;
  exp_t sb[$];

  seg_mmio #(.BASE_ADDR(B), .SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .enabler(enabler), .write_enabler(write_enabler),
    .addr(addr), .select(select), .data_input(data_input),
    .data_output(data_output), .hit(hit), .seg(seg), .an(an), .dp(dp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  function automatic logic [6:0] hexseg(input logic [3:0] h);
    case (h)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    vectors++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h required=entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h required=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    enabler = 1; write_enabler = 1; addr = a; data_input = d; select = s;
    tick();
    enabler = 0; write_enabler = 0; select = 0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string tag);
    enabler = 1; write_enabler = 0; addr = a;
    push(tag, e);
    #1;
    chk(data_output);
    enabler = 0;
  endtask

  // Outputs after edge k show the scan state left by edge k-1.
  task automatic disp(input int n, input string tag);
    int i;
    logic off_n;
    for (int c = 0; c < n; c++) begin
      i = (cyc >> 2) & 3;
      off_n = !ctrl_m[0];
`ifdef SEG_MMIO_BLANK_LEADING_EN
      if (i != 0 && (data_m[15:0] >> (4 * i)) == 16'h0) off_n = 1;
`endif
      push({tag, "_an"}, {28'h0, off_n ? 4'hF : ~(4'b0001 << i)});
      push({tag, "_seg"}, {25'h0, off_n ? 7'h7F : hexseg(data_m[4*i +: 4])});
      push({tag, "_dp"}, {31'h0, off_n | ~ctrl_m[4+i]});
      tick();
      chk({28'h0, an});
      chk({25'h0, seg});
      chk({31'h0, dp});
    end
  endtask

  initial begin
    wr(B, 32'hDEAD_BEEF, 4'hF);
    tick();
    tick();
    rst = 0;
    disp(1, "reset_out");
    rd(B + 4, 32'h1, "reset_ctrl");
    rd(B, 32'h0, "reset_wr_ignored");
    wr(B, 32'hAABB_1234, 4'b0001);
    data_m = 32'h34;
    rd(B, 32'h34, "byte_sel");
    wr(B, 32'h0000_1234, 4'hF);
    data_m = 32'h1234;
    rd(B, 32'h1234, "data_rd");
    disp(20, "scan");
    wr(B + 4, 32'h0, 4'hF);
    ctrl_m = 32'h0;
    disp(1, "disable");
    rd(B + 8, (cyc >> 2) & 3, "status_a");
    disp(4, "disable_run");
    rd(B + 8, (cyc >> 2) & 3, "status_b");
    wr(B + 4, 32'h21, 4'hF);
    ctrl_m = 32'h21;
    rd(B + 4, 32'h21, "ctrl_rd");
    disp(16, "dpmask");
    enabler = 1; write_enabler = 0; addr = B + 32'h10;
    push("miss_hit", 0);
    push("miss_data", 0);
    #1;
    chk({31'h0, hit});
    chk(data_output);
    enabler = 0;
    wr(B + 32'h10, 32'hFFFF_FFFF, 4'hF);
    rd(B, 32'h1234, "miss_wr_ignored");
    wr(B + 8, 32'h3, 4'hF);
    rd(B + 8, (cyc >> 2) & 3, "status_ro");
    rd(B + 12, 32'h0, "rsvd_rd");
    rd(B + 14, 32'h1234 & 32'h0, "rsvd_lowbits");
    rd(B + 1, 32'h1234, "data_lowbits");
    disp(6, "prereset");
    rst = 1;
    tick();
    rst = 0;
    data_m = 0;
    ctrl_m = 32'h1;
    disp(6, "midreset");
    wr(B, 32'h5, 4'hF);
    data_m = 32'h5;
    disp(16, "blank");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/seg_mmio.md
SEG_MMIO -- requirements
Module: seg_mmio

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h0000_2000: 16-byte-aligned base address of the register window.
REQ-002 The block SHALL have parameter SCAN_DIV, default 50000: clk cycles per digit, legal range 1..65535.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit, SHALL be a synchronous, active-high reset.
REQ-005 Port enabler, input, 1 bit: bus access strobe from the CPU.
REQ-006 Port write_enabler, input, 1 bit: 1 means write, 0 means read.
REQ-007 Port addr, input, 32 bits: byte address.
REQ-008 Port select, input, 4 bits: byte-lane enables, where select[i] covers data bits [8i+7:8i].
REQ-009 Port data_input, input, 32 bits: write data.
REQ-010 Port data_output, output, 32 bits: read data.
REQ-011 Port hit, output, 1 bit: the current access decodes to this block.
REQ-012 Port seg, output, 7 bits, active-low, ordered {g,f,e,d,c,b,a}.
REQ-013 Port an, output, 4 bits, active-low digit anodes, where an[0] is the rightmost digit.
REQ-014 Port dp, output, 1 bit, active-low decimal point.

Function
REQ-015 hit SHALL be combinational: enabler && addr[31:4]==BASE_ADDR[31:4]; addr[1:0] is ignored.
REQ-016 Registers by offset addr[3:2] SHALL be as follows:
- 0 DATA: RW, 32 bits; only [15:0] is displayed.
- 1 CTRL: RW; bit0 display enable, bits[7:4] dp mask; all other bits read 0.
- 2 STATUS: RO; bits[1:0] current digit index, other bits 0.
- 3: reads 0.
REQ-017 A write SHALL occur on the rising edge when hit && write_enabler; only bytes whose select bit is 1 update; writes to STATUS and offset 3 SHALL be ignored.
REQ-018 data_output SHALL be combinational: the addressed register value when hit && !write_enabler, else 32'h0.
REQ-019 Prescaler cnt SHALL count 0..SCAN_DIV-1; when cnt==SCAN_DIV-1 it wraps to 0 and digit index idx advances 0->1->2->3->0.
REQ-020 With SCAN_DIV==1, idx SHALL advance every cycle.
REQ-021 When enabled (CTRL[0]=1), outputs SHALL be:
- an = ~(4'b0001<<idx);
- seg = decode of DATA[4*idx+3:4*idx];
- dp = ~CTRL[4+idx].
REQ-022 When disabled (CTRL[0]=0), outputs SHALL be an=4'b1111, seg=7'h7F, dp=1; the prescaler and idx SHALL keep running.
REQ-023 seg/an/dp SHALL be registered, updating one cycle after idx or register changes (one-cycle output latency).
REQ-024 A write coinciding with an idx advance SHALL take effect: the new value is shown for the new digit one cycle later.
REQ-025 A hex decode SHALL cover 0-F: 0=7'b1000000, 1=7'b1111001, 8=7'b0000000, F=7'b0001110.

Reset
REQ-026 While rst=1, DATA SHALL be 0, CTRL SHALL be 32'h1, cnt SHALL be 0 and idx SHALL be 0; bus writes SHALL be ignored.
REQ-027 On the cycle after rst deasserts, outputs SHALL be an=4'b1110, seg=7'b1000000, dp=1; data_output SHALL remain combinational through reset.
REQ-028 Reset asserted mid-scan SHALL restart at idx 0, cnt 0, with no partial-digit glitch beyond one cycle.

Configuration
REQ-029 With macro SEG_MMIO_BLANK_LEADING_EN defined, digit i>0 SHALL be blanked (an bit high, seg=7'h7F, dp=1) when DATA[15:4i] is all zero; digit 0 is never blanked. dp mask does not unblank.
REQ-030 Without SEG_MMIO_BLANK_LEADING_EN, all four digits SHALL always be shown when enabled.

Structure
REQ-031 Package seg_mmio_pkg SHALL hold the register offset constants, CTRL bit positions, the digit count (4) and the blank pattern 7'h7F.
REQ-032 The hex-to-segment table SHALL be the sub-module hex7seg_decode (4-bit in, 7-bit active-low out, purely combinational).

Verification
REQ-033 Reset check: hold rst for 3 cycles, then release -> an=4'b1110, seg=7'b1000000, dp=1, CTRL reads 32'h1.
REQ-034 Byte-select write: write DATA=32'hAABB_1234 with select=4'b0001 -> DATA reads 32'h0000_0034.
REQ-035 Scan sequence: SCAN_DIV=4, DATA=16'h1234 -> an steps 1110,1101,1011,0111 every 4 cycles, showing 4,3,2,1, and wraps back to 0.
REQ-036 Disable and dp: write CTRL=32'h0 -> an=4'b1111 next cycle with STATUS still advancing; then write CTRL=32'h21 -> dp=0 only while an=4'b1101.
REQ-037 Decode and read behaviour:
- addr=BASE_ADDR+32'h10 -> hit=0, data_output=0, and a write there changes nothing;
- a read at BASE_ADDR+8 returns the current idx;
- a read at BASE_ADDR+12 returns 0.
REQ-038 SEG_MMIO_BLANK_LEADING_EN: with the macro defined and DATA=16'h0005, only an[0] ever goes low (showing 5); without the macro, digits 3..1 show 0.
